// File: rtl/clock_pkg.sv
// Shared definitions for the clock datapath.
// Holds the legal maximum digit values for the seconds/minutes counters, the BCD
// digit type, a tens/units pair struct and the helper that computes the next
// value of such a pair on an increment.
// No ports (package).
package clock_pkg;

    localparam logic [2:0] SEC_MAX_HIGH = 3'd5;
    localparam logic [2:0] MIN_MAX_HIGH = 3'd5;
    localparam logic [3:0] BCD_MAX      = 4'd9;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        logic [2:0] high;
        bcd_t       low;
    } bcd_pair_t;

    // Next value of a tens/units pair after one increment. A units digit above 9
    // (only reachable by forcing) loads 0 without carrying. A tens digit at or
    // above its maximum loads 0 when the units digit carries into it.
    function automatic bcd_pair_t bcdPairInc(input bcd_pair_t cur, input logic [2:0] maxHigh);
        bcd_pair_t nxt;
        nxt = cur;
        if (cur.low >= BCD_MAX) begin
            nxt.low = '0;
            if (cur.low == BCD_MAX) begin
                if (cur.high >= maxHigh) begin
                    nxt.high = '0;
                end else begin
                    nxt.high = cur.high + 3'd1;
                end
            end
        end else begin
            nxt.low = cur.low + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter running 00..(MAX_HIGH)9, i.e. 00..59 by default.
// Ports:
//   rst   in  asynchronous active-low reset, clears the pair to 00
//   clk   in  clock
//   inc   in  advance by one on the next edge
//   clr   in  load 00 on the next edge; has priority over inc
//   low   out units digit, BCD 0..9
//   high  out tens digit, 0..MAX_HIGH
//   carry out combinational: inc while the pair sits at its maximum value
module bcd_mod60
    import clock_pkg::*;
#(
    parameter logic [2:0] MAX_HIGH = SEC_MAX_HIGH
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] low,
    output logic [2:0] high,
    output logic       carry
);

    bcd_pair_t pair_q;
    bcd_pair_t pair_d;

    // Clear wins over increment so a coincident clear never lets the pair advance.
    always_comb begin
        pair_d = pair_q;
        if (clr) begin
            pair_d = '0;
        end else if (inc) begin
            pair_d = bcdPairInc(pair_q, MAX_HIGH);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair_q <= '0;
        end else begin
            pair_q <= pair_d;
        end
    end

    // The carry ignores clr; callers that need clear-wins semantics mask inc.
    assign carry = inc && (pair_q.low == BCD_MAX) && (pair_q.high == MAX_HIGH);

    assign low  = pair_q.low;
    assign high = pair_q.high;

endmodule

// File: rtl/min_sec_counter.sv
// Seconds/minutes timebase for the 24-hour clock.
// Divides clk down to a once-per-second tick, counts seconds and minutes as BCD
// pairs 00..59 and pulses hr_inc on each 59:59 -> 00:00 rollover for the hour
// counter. min_inc and sec_clr support time-set mode.
// Parameter TICK_DIV (>= 2): clk cycles per second tick.
// Ports:
//   rst      in  asynchronous active-low reset
//   clk      in  clock
//   enable   in  count enable, shared with the hour counter
//   min_inc  in  minutes +1 pulse, never carries into hours
//   sec_clr  in  clears seconds and the prescaler
//   sec_low  out seconds units (BCD)      sec_high out seconds tens
//   min_low  out minutes units (BCD)      min_high out minutes tens
//   tick_1hz out registered one-cycle pulse per second tick
//   hr_inc   out registered one-cycle pulse per hour rollover
module min_sec_counter
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       enable,
    input  logic       min_inc,
    input  logic       sec_clr,
    output logic [3:0] sec_low,
    output logic [2:0] sec_high,
    output logic [3:0] min_low,
    output logic [2:0] min_high,
    output logic       tick_1hz,
    output logic       hr_inc
);

    localparam int                 PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               tick;
    logic               secInc;
    logic               secCarry;
    logic               minInc;
    logic               minCarry;
    logic               tick_q;
    logic               hrInc_q;
    logic               hrInc_d;

    assign tick = enable && (presc_q == PRESC_LAST);

    // Prescaler: sec_clr restarts the second regardless of enable.
    always_comb begin
        presc_d = presc_q;
        if (sec_clr) begin
            presc_d = '0;
        end else if (enable) begin
            if (tick) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    // Masking the seconds increment with sec_clr also kills any minute carry.
    assign secInc = tick && !sec_clr;

    // A carry and a manual min_inc in the same cycle advance minutes only once.
    assign minInc = secCarry || min_inc;

    // min_inc suppresses the hour carry even when a real carry coincides.
    assign hrInc_d = minCarry && !min_inc;

    bcd_mod60 #(
        .MAX_HIGH(SEC_MAX_HIGH)
    ) uSeconds (
        .rst  (rst),
        .clk  (clk),
        .inc  (secInc),
        .clr  (sec_clr),
        .low  (sec_low),
        .high (sec_high),
        .carry(secCarry)
    );

    bcd_mod60 #(
        .MAX_HIGH(MIN_MAX_HIGH)
    ) uMinutes (
        .rst  (rst),
        .clk  (clk),
        .inc  (minInc),
        .clr  (1'b0),
        .low  (min_low),
        .high (min_high),
        .carry(minCarry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            hrInc_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick;
            hrInc_q <= hrInc_d;
        end
    end

    assign tick_1hz = tick_q;
    assign hr_inc   = hrInc_q;

endmodule

// File: tb/tb_min_sec_counter.sv
// Directed bench for min_sec_counter with TICK_DIV = 4.
module tb_min_sec_counter;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       min_inc;
    logic       sec_clr;
    logic [3:0] sec_low;
    logic [2:0] sec_high;
    logic [3:0] min_low;
    logic [2:0] min_high;
    logic       tick_1hz;
    logic       hr_inc;

    int checkCount = 0;
    int passCount  = 0;
    int tickCount;
    int hrCount;

    min_sec_counter #(
        .TICK_DIV(4)
    ) dut (
        .rst     (rst),
        .clk     (clk),
        .enable  (enable),
        .min_inc (min_inc),
        .sec_clr (sec_clr),
        .sec_low (sec_low),
        .sec_high(sec_high),
        .min_low (min_low),
        .min_high(min_high),
        .tick_1hz(tick_1hz),
        .hr_inc  (hr_inc)
    );

    // 10 time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Time packed as 16'hMMSS so expected values read like the clock face.
    function automatic logic [15:0] timeNow();
        return {1'b0, min_high, min_low, 1'b0, sec_high, sec_low};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic en, input logic mi, input logic sc);
        enable  = en;
        min_inc = mi;
        sec_clr = sc;
    endtask

    // Advance n rising edges, leaving time 1 unit after the last edge.
    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseMinInc(input logic en, input int n);
        repeat (n) begin
            applyStimulus(en, 1'b1, 1'b0);
            stepCycles(1);
        end
        applyStimulus(en, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycles(3);
        checkOutput("resetTime", timeNow(), 16'h0000);
        checkOutput("resetTick", {15'd0, tick_1hz}, 16'd0);
        checkOutput("resetHr", {15'd0, hr_inc}, 16'd0);

        // First ticks after release land on edges 4, 8, 12.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            stepCycles(1);
            checkOutput($sformatf("tickEdge%0d", i), {15'd0, tick_1hz}, {15'd0, (i % 4 == 0)});
        end
        checkOutput("after3Ticks", timeNow(), 16'h0003);

        // Reset asserted asynchronously while tick_1hz is high.
        stepCycles(4);
        checkOutput("preResetTime", timeNow(), 16'h0004);
        rst = 1'b0;
        #1;
        checkOutput("midResetTime", timeNow(), 16'h0000);
        checkOutput("midResetTick", {15'd0, tick_1hz}, 16'd0);
        stepCycles(1);
        rst = 1'b1;

        // Sixty ticks from 00:00.
        tickCount = 0;
        hrCount   = 0;
        repeat (240) begin
            stepCycles(1);
            if (tick_1hz) tickCount++;
            if (hr_inc) hrCount++;
        end
        checkOutput("sixtyTicksTime", timeNow(), 16'h0100);
        checkOutput("sixtyTicksCount", tickCount[15:0], 16'd60);
        checkOutput("sixtyTicksHr", hrCount[15:0], 16'd0);

        // Enable hold with prescaler at 2.
        stepCycles(22);
        checkOutput("holdStart", timeNow(), 16'h0105);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tickCount = 0;
        repeat (10) begin
            stepCycles(1);
            if (tick_1hz) tickCount++;
        end
        checkOutput("holdTime", timeNow(), 16'h0105);
        checkOutput("holdTicks", tickCount[15:0], 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("resumeEdge1", {15'd0, tick_1hz}, 16'd0);
        stepCycles(1);
        checkOutput("resumeEdge2", {15'd0, tick_1hz}, 16'd1);
        checkOutput("resumeTime", timeNow(), 16'h0106);

        // Preset 59:58, then hour rollover.
        applyStimulus(1'b0, 1'b0, 1'b1);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("secClrTime", timeNow(), 16'h0100);
        pulseMinInc(1'b0, 58);
        checkOutput("presetMin", timeNow(), 16'h5900);
        checkOutput("presetMinHr", {15'd0, hr_inc}, 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycles(232);
        checkOutput("preset5958", timeNow(), 16'h5958);
        stepCycles(4);
        checkOutput("at5959", timeNow(), 16'h5959);
        stepCycles(3);
        checkOutput("preRollHr", {15'd0, hr_inc}, 16'd0);
        stepCycles(1);
        checkOutput("rollTime", timeNow(), 16'h0000);
        checkOutput("rollHr", {15'd0, hr_inc}, 16'd1);
        stepCycles(1);
        checkOutput("rollHrDrop", {15'd0, hr_inc}, 16'd0);

        // sec_clr coincident with a tick at 00:59 (prescaler now 1).
        stepCycles(235);
        checkOutput("at0059", timeNow(), 16'h0059);
        stepCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b1);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("clrWinsTime", timeNow(), 16'h0000);
        checkOutput("clrWinsHr", {15'd0, hr_inc}, 16'd0);

        // min_inc coincident with a tick at 59:59.
        pulseMinInc(1'b0, 59);
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycles(236);
        checkOutput("second5959", timeNow(), 16'h5959);
        stepCycles(3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("incWithCarryTime", timeNow(), 16'h0000);
        checkOutput("incWithCarryHr", {15'd0, hr_inc}, 16'd0);
        stepCycles(1);
        checkOutput("incWithCarryHrLate", {15'd0, hr_inc}, 16'd0);

        // Set wrap at 59:30 (prescaler now 1, so three edges to the first tick).
        pulseMinInc(1'b0, 59);
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycles(3);
        stepCycles(29 * 4);
        checkOutput("at5930", timeNow(), 16'h5930);
        pulseMinInc(1'b1, 1);
        checkOutput("setWrapTime", timeNow(), 16'h0030);
        checkOutput("setWrapHr", {15'd0, hr_inc}, 16'd0);
        stepCycles(3);
        checkOutput("setWrapContinue", timeNow(), 16'h0031);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/min_sec_counter.md
# min_sec_counter

Seconds/minutes timebase for the 24-hour clock. It divides `clk` down to a 1 Hz tick, keeps seconds and minutes as BCD digit pairs (00–59), and emits a single-cycle `hr_inc` pulse on every 59:59→00:00 rollover. That pulse feeds the `hr_inc` input of the downstream hour counter, which shares `enable` with this block. Also supports manual minute setting and seconds clearing for time-set mode.

## Interface
- `TICK_DIV`, default 50_000_000: `clk` cycles per second tick; must be ≥ 2. Prescaler width is `$clog2(TICK_DIV)`.
- `rst`  in  1  reset, asynchronous, active-low
- `clk`  in  1  clock
- `enable`  in  1  count enable; synchronous to `clk`; shared with the hour counter
- `min_inc`  in  1  single-cycle set pulse: minutes +1, no carry into hours
- `sec_clr`  in  1  single-cycle pulse: seconds and prescaler to 0
- `sec_low`  out  4  seconds units, BCD 0–9
- `sec_high`  out  3  seconds tens, 0–5
- `min_low`  out  4  minutes units, BCD 0–9
- `min_high`  out  3  minutes tens, 0–5
- `tick_1hz`  out  1  registered; high one cycle per second tick
- `hr_inc`  out  1  registered; high one cycle per 59:59 rollover

## Operation
- **Reset (`rst`=0).** All outputs are 0, i.e. time 00:00, and the prescaler is 0. State is cleared immediately on assertion, including mid-operation, and any pending `hr_inc` or `tick_1hz` is dropped.
- **Prescaler.**
  - When `enable`=1: counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and generates an internal tick.
  - When `enable`=0: holds its value; no ticks are generated.
- **On tick:**
  - `sec_low` +1. At 9 it wraps to 0 and `sec_high` +1.
  - At 59 seconds: seconds go to 00 and carry into minutes.
  - Minutes follow the same 00–59 rule. A minute carry at 59 sets minutes to 00 and raises `hr_inc`.
- **`min_inc`.** Minutes +1, wrapping 59→00 without `hr_inc`. Seconds and prescaler are untouched. It acts regardless of `enable`.
- **`sec_clr`.** Seconds go to 00 and prescaler to 0, regardless of `enable`. No carry is produced.
- **Simultaneous events:**
  - `sec_clr` with a tick: `sec_clr` wins; no seconds advance and no minute carry.
  - `min_inc` with a tick that carries into minutes: minutes advance by exactly 1, not 2. `hr_inc` is raised only if the carry alone would cause the 59→00 wrap and `min_inc` is not asserted; `min_inc` suppresses the hour carry.
  - `min_inc` together with `sec_clr`: both apply.
- **Unreachable values.** Digit values outside the legal range cannot occur. If forced, the next increment of that digit loads 0.

## Timing
- `tick_1hz` and `hr_inc` are registered and assert in the cycle right after the edge that updates the counters. They are high for exactly one cycle.
- The hour counter samples `hr_inc` on the following edge, so the hour updates one cycle after minutes show 00.
- With `enable` held at 1, ticks are exactly TICK_DIV cycles apart. The first tick after reset arrives at cycle TICK_DIV.
- `enable` must not fall in the cycle `hr_inc` is high; the system controller guarantees this. The block does not gate `hr_inc` with `enable`.
- `min_inc` and `sec_clr` take effect on the next `clk` edge and are visible on the outputs one cycle after being sampled.

## Structure
- **Shared package `clock_pkg`:**
  - constants `SEC_MAX_HIGH=5`, `MIN_MAX_HIGH=5`, `BCD_MAX=9`;
  - typedef `bcd_t` (logic [3:0]);
  - a struct for a tens/units pair.
- **Sub-module `bcd_mod60`:**
  - ports: `rst`, `clk`, `inc`, `clr`, `low`, `high`, `carry`;
  - `carry` is combinational and equals `inc` && value==59;
  - instantiated twice, for seconds and minutes.
- The prescaler and output pulse registers live in the top module.

## Test plan
Run with TICK_DIV=4.
- **Reset:** assert `rst`=0 mid-count → all outputs 0 immediately. Release → `tick_1hz` first high at cycle 4, then every 4 cycles.
- **Seconds rollover:** run 60 ticks from 00:00 → reads 01:00. `tick_1hz` pulsed 60 times, `hr_inc` never.
- **Hour rollover:** preset 59:58 via `min_inc`, then run 2 ticks → outputs 00:00. `hr_inc` high exactly one cycle, the cycle after 00:00 appears.
- **Enable hold:** drop `enable` for 10 cycles at 00:05 with prescaler=2 → value frozen. On re-enable, the next tick arrives 2 cycles later.
- **Priority:** at 00:59, `sec_clr` coincident with a tick → 00:00, no minute change. At 59:59, `min_inc` coincident with a tick → 00:00 with `hr_inc`=0.
- **Set wrap:** at 59:30, pulse `min_inc` → 00:30, `hr_inc`=0, seconds continue counting from 30.
